regfile_param_clr: RTL and testbench

//   Parametrised register file (WIDTH x DEPTH): one synchronous write port, two asynchronous read ports.

---
 rtl/regfile_param_clr_if.sv | 31 +++
 rtl/regfile_param_clr.sv | 104 ++++++++++
 tb/tb_regfile_param_clr.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_param_clr_if.sv
// Bus bundle for regfile_param_clr: write port, clear control and the two read ports.
// clk and reset stay outside the bundle as plain ports of the register file.
interface regfile_param_clr_if #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
);
  localparam int ADDR_W = $clog2(DEPTH);

  logic              write;
  logic [ADDR_W-1:0] wrAddr;
  logic [WIDTH-1:0]  wrData;
  logic              clear;
  logic              busy;
  logic              wrErr;
  logic [ADDR_W-1:0] rdAddrA;
  logic [WIDTH-1:0]  rdDataA;
  logic              rdValidA;
  logic [ADDR_W-1:0] rdAddrB;
  logic [WIDTH-1:0]  rdDataB;
  logic              rdValidB;

  modport master (
    output write, wrAddr, wrData, clear, rdAddrA, rdAddrB,
    input  busy, wrErr, rdDataA, rdValidA, rdDataB, rdValidB
  );

  modport slave (
    input  write, wrAddr, wrData, clear, rdAddrA, rdAddrB,
    output busy, wrErr, rdDataA, rdValidA, rdDataB, rdValidB
  );
endinterface

// File: rtl/regfile_param_clr.sv
// WIDTH x DEPTH register file: one synchronous write port, two combinational read ports,
// per-entry valid bits, optional write bypass / hardwired zero register, and a sweep-clear engine.
module regfile_param_clr #(
  parameter int WIDTH     = 16,
  parameter int DEPTH     = 8,
  parameter int BYPASS    = 1,
  parameter int ZERO_REG0 = 0
) (
  input  logic               clk,
  input  logic               reset,
  regfile_param_clr_if.slave bus
);
  localparam int ADDR_W     = $clog2(DEPTH);
  localparam bit USE_BYPASS = (BYPASS != 0);
  localparam bit USE_ZERO   = (ZERO_REG0 != 0);

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t            state;
  state_t            state_nx;
  logic [ADDR_W-1:0] idx;
  logic              sweep_done;
  logic              wr_acc;
  logic              wr_zero;
  logic              wr_err;

  logic [WIDTH-1:0]  mem [DEPTH];
  logic [DEPTH-1:0]  vld;

  logic [ADDR_W-1:0] rd_addr  [2];
  logic [WIDTH-1:0]  rd_data  [2];
  logic              rd_valid [2];

  assign sweep_done = (idx == ADDR_W'(DEPTH - 1));
  assign wr_zero    = USE_ZERO && (bus.wrAddr == '0);
  // Writes to the hardwired zero register are silently dropped, never flagged.
  assign wr_acc     = bus.write && (state == IDLE) && !wr_zero;

  // NOTE: combinational blocks assign every output a default first so no latch is inferred.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  if (bus.clear) state_nx = CLEAR;
      CLEAR: if (sweep_done) state_nx = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only; combinational logic uses blocking.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      idx    <= '0;
      wr_err <= 1'b0;
    end else begin
      state  <= state_nx;
      wr_err <= bus.write && (state == CLEAR);
      // Index free-runs through the sweep and wraps back to 0 on the final entry.
      if (state == CLEAR) idx <= idx + 1'b1;
      else                idx <= '0;
    end
  end

  // NOTE: the array carries an async reset because the whole file must read zero immediately on reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      vld <= '0;
    end else if (state == CLEAR) begin
      mem[idx] <= '0;
      vld[idx] <= 1'b0;
    end else if (wr_acc) begin
      mem[bus.wrAddr] <= bus.wrData;
      vld[bus.wrAddr] <= 1'b1;
    end
  end

  assign rd_addr[0] = bus.rdAddrA;
  assign rd_addr[1] = bus.rdAddrB;

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rd_data[p]  = mem[rd_addr[p]];
      rd_valid[p] = vld[rd_addr[p]];
      if (USE_BYPASS && wr_acc && (bus.wrAddr == rd_addr[p])) begin
        rd_data[p]  = bus.wrData;
        rd_valid[p] = 1'b1;
      end
      if (USE_ZERO && (rd_addr[p] == '0)) begin
        rd_data[p]  = '0;
        rd_valid[p] = 1'b0;
      end
    end
  end

  assign bus.rdDataA  = rd_data[0];
  assign bus.rdValidA = rd_valid[0];
  assign bus.rdDataB  = rd_data[1];
  assign bus.rdValidB = rd_valid[1];
  assign bus.busy     = (state == CLEAR);
  assign bus.wrErr    = wr_err;
endmodule

// File: tb/tb_regfile_param_clr.sv
// Scoreboard bench: unit A is 8x16 with bypass, unit B is 16x32 without bypass and with zero reg 0.
// Stimulus pushes expected read-port/status values; a negedge monitor pops and compares them.
module tb_regfile_param_clr;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  regfile_param_clr_if #(.WIDTH(16), .DEPTH(8))  ifa ();
  regfile_param_clr_if #(.WIDTH(32), .DEPTH(16)) ifb ();

  regfile_param_clr #(.WIDTH(16), .DEPTH(8), .BYPASS(1), .ZERO_REG0(0)) u_a (
    .clk(clk), .reset(reset), .bus(ifa)
  );
  regfile_param_clr #(.WIDTH(32), .DEPTH(16), .BYPASS(0), .ZERO_REG0(1)) u_b (
    .clk(clk), .reset(reset), .bus(ifb)
  );

  typedef struct {
    string       name;
    bit          unit;
    logic [31:0] ad;
    logic        av;
    logic [31:0] bd;
    logic        bv;
    logic        bz;
    logic        we;
  } exp_t;

  exp_t        sb [$];
  int          n_checks = 0;
  int          n_errors = 0;
  logic [15:0] mem_a [8];
  logic        va    [8];
  logic [31:0] mem_b [16];
  logic        vb    [16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input logic w, input logic [2:0] wa, input logic [15:0] wd,
                         input logic c, input logic [2:0] ra, input logic [2:0] rb);
    ifa.write = w; ifa.wrAddr = wa; ifa.wrData = wd; ifa.clear = c;
    ifa.rdAddrA = ra; ifa.rdAddrB = rb;
  endtask

  task automatic drive_b(input logic w, input logic [3:0] wa, input logic [31:0] wd,
                         input logic c, input logic [3:0] ra, input logic [3:0] rb);
    ifb.write = w; ifb.wrAddr = wa; ifb.wrData = wd; ifb.clear = c;
    ifb.rdAddrA = ra; ifb.rdAddrB = rb;
  endtask

  task automatic expect_a(input string n, input logic [15:0] ad, input logic av,
                          input logic [15:0] bd, input logic bv, input logic bz, input logic we);
    sb.push_back('{n, 1'b0, 32'(ad), av, 32'(bd), bv, bz, we});
  endtask

  task automatic expect_b(input string n, input logic [31:0] ad, input logic av,
                          input logic [31:0] bd, input logic bv, input logic bz, input logic we);
    sb.push_back('{n, 1'b1, ad, av, bd, bv, bz, we});
  endtask

  task automatic clear_models();
    for (int i = 0; i < 8; i++) begin mem_a[i] = '0; va[i] = 1'b0; end
    for (int i = 0; i < 16; i++) begin mem_b[i] = '0; vb[i] = 1'b0; end
  endtask

  // Monitor: compares every pending expectation against the live outputs on the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (sb.size() > 0) begin
        e = sb.pop_front();
        if (e.unit == 1'b0) begin
          check({e.name, ".rdDataA"},  32'(ifa.rdDataA),  e.ad);
          check({e.name, ".rdValidA"}, 32'(ifa.rdValidA), 32'(e.av));
          check({e.name, ".rdDataB"},  32'(ifa.rdDataB),  e.bd);
          check({e.name, ".rdValidB"}, 32'(ifa.rdValidB), 32'(e.bv));
          check({e.name, ".busy"},     32'(ifa.busy),     32'(e.bz));
          check({e.name, ".wrErr"},    32'(ifa.wrErr),    32'(e.we));
        end else begin
          check({e.name, ".rdDataA"},  ifb.rdDataA,       e.ad);
          check({e.name, ".rdValidA"}, 32'(ifb.rdValidA), 32'(e.av));
          check({e.name, ".rdDataB"},  ifb.rdDataB,       e.bd);
          check({e.name, ".rdValidB"}, 32'(ifb.rdValidB), 32'(e.bv));
          check({e.name, ".busy"},     32'(ifb.busy),     32'(e.bz));
          check({e.name, ".wrErr"},    32'(ifb.wrErr),    32'(e.we));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [15:0] d16;
    logic [31:0] d32;
    logic [2:0]  ra3, rb3;
    logic [3:0]  ra4, rb4;

    reset = 1'b1;
    drive_a(0, 0, 0, 0, 0, 7);
    drive_b(0, 0, 0, 0, 0, 15);
    clear_models();
    tick();
    expect_a("reset_a", 0, 0, 0, 0, 0, 0);
    expect_b("reset_b", 0, 0, 0, 0, 0, 0);
    tick();
    reset = 1'b0;

    // Write 0x1234 to addr 3: visible in the write cycle only where bypass is on.
    drive_a(1, 3, 16'h1234, 0, 3, 3);
    drive_b(1, 3, 32'h1234, 0, 3, 3);
    expect_a("bypass_a",   16'h1234, 1, 16'h1234, 1, 0, 0);
    expect_b("nobypass_b", 0, 0, 0, 0, 0, 0);
    tick();
    mem_a[3] = 16'h1234; va[3] = 1'b1;
    mem_b[3] = 32'h1234; vb[3] = 1'b1;
    drive_a(0, 0, 0, 0, 3, 3);
    drive_b(0, 0, 0, 0, 3, 3);
    expect_a("after_wr_a", 16'h1234, 1, 16'h1234, 1, 0, 0);
    expect_b("after_wr_b", 32'h1234, 1, 32'h1234, 1, 0, 0);
    tick();

    // Zero register on unit B: write is discarded without error.
    drive_b(1, 0, 32'hFFFF, 0, 0, 3);
    expect_b("zero_wr_b", 0, 0, 32'h1234, 1, 0, 0);
    tick();
    drive_b(0, 0, 0, 0, 0, 0);
    expect_b("zero_after_b", 0, 0, 0, 0, 0, 0);
    tick();

    // Fill and read back: A ascending, B descending.
    for (int i = 0; i < 8; i++) begin
      d16 = 16'($urandom);
      drive_a(1, 3'(i), d16, 0, 0, 0);
      tick();
      mem_a[i] = d16; va[i] = 1'b1;
    end
    for (int i = 0; i < 8; i++) begin
      drive_a(0, 0, 0, 0, 3'(i), 3'(7 - i));
      expect_a($sformatf("fill_a[%0d]", i), mem_a[i], va[i], mem_a[7 - i], va[7 - i], 0, 0);
      tick();
    end
    for (int i = 0; i < 16; i++) begin
      d32 = $urandom;
      drive_b(1, 4'(i), d32, 0, 0, 0);
      tick();
      if (i != 0) begin mem_b[i] = d32; vb[i] = 1'b1; end
    end
    for (int i = 0; i < 16; i++) begin
      drive_b(0, 0, 0, 0, 4'(i), 4'(15 - i));
      expect_b($sformatf("fill_b[%0d]", i), mem_b[i], vb[i], mem_b[15 - i], vb[15 - i], 0, 0);
      tick();
    end

    // Clear on A combined with a same-cycle write to entry 7, then a rejected write while busy.
    drive_a(1, 7, 16'hBEEF, 1, 7, 0);
    expect_a("clr_start_a", 16'hBEEF, 1, mem_a[0], va[0], 0, 0);
    tick();
    mem_a[7] = 16'hBEEF; va[7] = 1'b1;
    for (int cyc = 1; cyc <= 9; cyc++) begin
      ra3 = (cyc == 2) ? 3'd4 : 3'(cyc - 1);
      rb3 = (cyc == 9) ? 3'd4 : 3'(cyc + 6);
      drive_a(cyc == 2, 4, 16'h0005, cyc == 3, ra3, rb3);
      expect_a($sformatf("clr_a[%0d]", cyc), mem_a[ra3], va[ra3], mem_a[rb3], va[rb3],
               cyc <= 8, cyc == 3);
      tick();
      if (cyc <= 8) begin mem_a[cyc - 1] = '0; va[cyc - 1] = 1'b0; end
    end
    drive_a(1, 4, 16'h0005, 0, 4, 4);
    expect_a("wr_after_clr_a", 16'h0005, 1, 16'h0005, 1, 0, 0);
    tick();
    mem_a[4] = 16'h0005; va[4] = 1'b1;
    drive_a(0, 0, 0, 0, 4, 3);
    expect_a("rd_after_clr_a", 16'h0005, 1, 0, 0, 0, 0);
    tick();

    // Clear on B: busy must last exactly 16 cycles.
    drive_b(0, 0, 0, 1, 0, 15);
    expect_b("clr_start_b", 0, 0, mem_b[15], vb[15], 0, 0);
    tick();
    for (int cyc = 1; cyc <= 17; cyc++) begin
      ra4 = 4'(cyc - 1);
      rb4 = 4'(cyc + 14);
      drive_b(0, 0, 0, 0, ra4, rb4);
      expect_b($sformatf("clr_b[%0d]", cyc), mem_b[ra4], vb[ra4], mem_b[rb4], vb[rb4],
               cyc <= 16, 0);
      tick();
      if (cyc <= 16) begin mem_b[cyc - 1] = '0; vb[cyc - 1] = 1'b0; end
    end

    // Refill A, start a sweep, and reset in the middle of it.
    for (int i = 0; i < 8; i++) begin
      d16 = 16'($urandom) | 16'h0001;
      drive_a(1, 3'(i), d16, 0, 0, 0);
      tick();
      mem_a[i] = d16; va[i] = 1'b1;
    end
    drive_a(0, 0, 0, 1, 5, 7);
    expect_a("clr2_start_a", mem_a[5], va[5], mem_a[7], va[7], 0, 0);
    tick();
    drive_a(0, 0, 0, 0, 5, 7);
    expect_a("clr2_busy_a", mem_a[5], va[5], mem_a[7], va[7], 1, 0);
    tick();
    reset = 1'b1;
    drive_b(0, 0, 0, 0, 3, 15);
    expect_a("rst_mid_a", 0, 0, 0, 0, 0, 0);
    expect_b("rst_mid_b", 0, 0, 0, 0, 0, 0);
    clear_models();
    tick();
    drive_a(0, 0, 0, 0, 1, 2);
    expect_a("rst_hold_a", 0, 0, 0, 0, 0, 0);
    tick();
    reset = 1'b0;
    drive_a(1, 2, 16'hA5A5, 0, 2, 6);
    expect_a("post_rst_wr_a", 16'hA5A5, 1, 0, 0, 0, 0);
    tick();
    drive_a(0, 0, 0, 0, 2, 6);
    expect_a("post_rst_rd_a", 16'hA5A5, 1, 0, 0, 0, 0);
    tick();

    repeat (2) tick();
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
